hack_cpu_ctrl: RTL and testbench

- Multi-cycle Hack instruction sequencer that sits directly upstream of the 16-bit Hack ALU.
- Owns the A, D, PC and IR registers and fetches instructions over a req/ack instruction-memory port.
- Drives the ALU operand and operation inputs, then consumes the ALU result and zr/ng flags for register writeback, data-memory writeback and jump resolution.

---
 rtl/hack_cpu_ctrl.sv | 155 +++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack instruction sequencer: fetches over imem, drives an external
// combinational ALU, and resolves writeback, data-memory stores and jumps.
module hack_cpu_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ack,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [5:0]  alu_op,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic [15:0] pc,
   output logic        retire
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MEMRD  = 3'd2,
      EXEC   = 3'd3,
      MEMWR  = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] pc_reg, pc_next;
   logic [15:0] a_reg, a_next;
   logic [15:0] d_reg, d_next;
   logic [15:0] ir_reg, ir_next;
   logic [15:0] m_reg, m_next;
   logic [15:0] wr_addr_reg, wr_addr_next;
   logic [15:0] wr_data_reg, wr_data_next;
   logic [15:0] pc_inc;
   logic        jmp;
   logic        fetch_active;
   logic        unused_ir_bits;

   assign pc_inc         = pc_reg + 16'd1;
   assign jmp            = (ir_reg[2] & alu_ng) | (ir_reg[1] & alu_zr) |
                           (ir_reg[0] & ~alu_ng & ~alu_zr);
   assign unused_ir_bits = ^ir_reg[14:13];

   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign alu_op    = ir_reg[11:6];
   assign alu_x     = d_reg;
   assign alu_y     = ir_reg[12] ? m_reg : a_reg;
   // State is already FETCH while reset is held, so mask the request there.
   assign imem_req  = fetch_active & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         pc_reg      <= RESET_PC;
         a_reg       <= 16'h0000;
         d_reg       <= 16'h0000;
         ir_reg      <= 16'h0000;
         m_reg       <= 16'h0000;
         wr_addr_reg <= 16'h0000;
         wr_data_reg <= 16'h0000;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         a_reg       <= a_next;
         d_reg       <= d_next;
         ir_reg      <= ir_next;
         m_reg       <= m_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      a_next       = a_reg;
      d_next       = d_reg;
      ir_next      = ir_reg;
      m_next       = m_reg;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      fetch_active = 1'b0;
      dmem_re      = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = 16'h0000;
      dmem_wdata   = 16'h0000;
      retire       = 1'b0;

      case (state_reg)
         FETCH: begin
            fetch_active = 1'b1;
            if (imem_ack) begin
               ir_next    = imem_rdata;
               state_next = DECODE;
            end
         end
         DECODE: begin
            if (!ir_reg[15]) begin
               a_next     = ir_reg;
               pc_next    = pc_inc;
               retire     = 1'b1;
               state_next = FETCH;
            end else if (ir_reg[12]) begin
               state_next = MEMRD;
            end else begin
               state_next = EXEC;
            end
         end
         MEMRD: begin
            dmem_re   = 1'b1;
            dmem_addr = a_reg;
            if (dmem_ack) begin
               m_next     = dmem_rdata;
               state_next = EXEC;
            end
         end
         EXEC: begin
            // Jump target and store address both use A as it was before writeback.
            if (ir_reg[5]) a_next = alu_out;
            if (ir_reg[4]) d_next = alu_out;
            pc_next = jmp ? a_reg : pc_inc;
            if (ir_reg[3]) begin
               wr_addr_next = a_reg;
               wr_data_next = alu_out;
               state_next   = MEMWR;
            end else begin
               retire     = 1'b1;
               state_next = FETCH;
            end
         end
         MEMWR: begin
            dmem_we    = 1'b1;
            dmem_addr  = wr_addr_reg;
            dmem_wdata = wr_data_reg;
            if (dmem_ack) begin
               retire     = 1'b1;
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomized bench for hack_cpu_ctrl: an ISA-level model predicts data accesses
// and retire PCs into a queue that a monitor checks against the DUT's outputs.
module tb_hack_cpu_ctrl;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam int          N_RETIRE = 400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack = 1'b0;
   logic [15:0] imem_addr, imem_rdata = 16'h0000;
   logic        dmem_re, dmem_we, dmem_ack = 1'b0;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata = 16'h0000;
   logic [5:0]  alu_op;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        alu_zr, alu_ng;
   logic [15:0] pc;
   logic        retire;

   hack_cpu_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
      .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc), .retire(retire)
   );

   always #5 clk = ~clk;

   // Gate-level Hack ALU as the DUT's environment.
   logic [15:0] ax1, ax2, ay1, ay2, af;
   assign ax1     = alu_op[5] ? 16'h0000 : alu_x;
   assign ax2     = alu_op[4] ? ~ax1 : ax1;
   assign ay1     = alu_op[3] ? 16'h0000 : alu_y;
   assign ay2     = alu_op[2] ? ~ay1 : ay1;
   assign af      = alu_op[1] ? (ax2 + ay2) : (ax2 & ay2);
   assign alu_out = alu_op[0] ? ~af : af;
   assign alu_zr  = (alu_out == 16'h0000);
   assign alu_ng  = alu_out[15];

   typedef struct {
      int          kind;   // 0 = data read, 1 = data write, 2 = retire
      logic [15:0] addr;   // data address, or PC after retire
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] prog_q[$];
   logic [15:0] ref_mem [256];
   logic [15:0] env_mem [256];
   logic [15:0] m_a, m_d, m_pc;
   logic [5:0]  comp_tab [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                  6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                  6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                  6'b000111, 6'b000000, 6'b010101};
   int  n_checks = 0;
   int  n_fail = 0;
   int  retire_cnt = 0;
   bit  gen_random = 1'b0;
   bit  hold_wr = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] d,
                                           input logic [15:0] y);
      case (c)
         6'b101010: return 16'd0;
         6'b111111: return 16'd1;
         6'b111010: return 16'hFFFF;
         6'b001100: return d;
         6'b110000: return y;
         6'b001101: return ~d;
         6'b110001: return ~y;
         6'b001111: return -d;
         6'b110011: return -y;
         6'b011111: return d + 16'd1;
         6'b110111: return y + 16'd1;
         6'b001110: return d - 16'd1;
         6'b110010: return y - 16'd1;
         6'b000010: return d + y;
         6'b010011: return d - y;
         6'b000111: return y - d;
         6'b000000: return d & y;
         6'b010101: return d | y;
         default:   return 16'd0;
      endcase
   endfunction

   task automatic push_exp(input int k, input logic [15:0] a, input logic [15:0] dt);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = dt;
      exp_q.push_back(e);
   endtask

   // Architectural effect of one instruction, applied when it is handed to the DUT.
   task automatic model_exec(input logic [15:0] ins);
      logic [15:0] y, r, a_old;
      logic        j;
      if (!ins[15]) begin
         m_a  = ins;
         m_pc = m_pc + 16'd1;
      end else begin
         y = ins[12] ? ref_mem[m_a[7:0]] : m_a;
         if (ins[12]) push_exp(0, m_a, 16'h0000);
         r     = ref_alu(ins[11:6], m_d, y);
         a_old = m_a;
         j = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) || (ins[0] && $signed(r) > 0);
         if (ins[5]) m_a = r;
         if (ins[4]) m_d = r;
         if (ins[3]) begin
            push_exp(1, a_old, r);
            ref_mem[a_old[7:0]] = r;
         end
         m_pc = j ? a_old : m_pc + 16'd1;
      end
      push_exp(2, m_pc, 16'h0000);
   endtask

   function automatic logic [15:0] gen_instr();
      logic [15:0] ins;
      if (prog_q.size() > 0) return prog_q.pop_front();
      if ($urandom_range(0, 9) < 4) begin
         ins = {1'b0, 15'($urandom)};
         if ($urandom_range(0, 1) == 1) ins[14:8] = 7'd0;
      end else begin
         ins = {3'b111, 1'($urandom), comp_tab[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
      end
      return ins;
   endfunction

   // Memory responder: random wait states, model prediction at fetch issue.
   initial begin : responder
      logic [15:0] cur_ins;
      bit ipend, dpend;
      int idel, ddel;
      ipend = 0; dpend = 0; idel = 0; ddel = 0; cur_ins = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         if (!rst_n) begin
            ipend = 0;
            dpend = 0;
            exp_q.delete();
            m_a  = 16'h0000;
            m_d  = 16'h0000;
            m_pc = RST_PC;
            continue;
         end
         if (imem_req && !ipend && (gen_random || prog_q.size() > 0)) begin
            cur_ins = gen_instr();
            check("fetch_addr", imem_addr, m_pc);
            model_exec(cur_ins);
            ipend = 1;
            idel  = $urandom_range(0, 2);
         end
         if (imem_req && ipend) begin
            if (idel == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = cur_ins;
               ipend      = 0;
            end else idel--;
         end
         if ((dmem_re || dmem_we) && !dpend) begin
            dpend = 1;
            ddel  = $urandom_range(0, 2);
         end
         if ((dmem_re || dmem_we) && dpend && !(dmem_we && hold_wr)) begin
            if (ddel == 0) begin
               dmem_ack = 1'b1;
               if (dmem_re) dmem_rdata = env_mem[dmem_addr[7:0]];
               else env_mem[dmem_addr[7:0]] = dmem_wdata;
               dpend = 0;
            end else ddel--;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT completes an access or retires.
   initial begin : monitor
      exp_t e;
      bit pc_pend;
      logic [15:0] pc_exp;
      pc_pend = 0; pc_exp = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pc_pend = 0;
            continue;
         end
         if (pc_pend) begin
            check("pc_after_retire", pc, pc_exp);
            pc_pend = 0;
         end
         if (dmem_re && dmem_we) check("re_we_exclusive", 16'd1, 16'd0);
         if (dmem_ack && (dmem_re || dmem_we)) begin
            if (exp_q.size() == 0) check("unexpected_dmem", 16'd1, 16'd0);
            else begin
               e = exp_q.pop_front();
               check("dmem_kind", dmem_we ? 16'd1 : 16'd0, 16'(e.kind));
               check("dmem_addr", dmem_addr, e.addr);
               if (dmem_we) check("dmem_wdata", dmem_wdata, e.data);
            end
         end
         if (retire) begin
            retire_cnt++;
            if (exp_q.size() == 0) check("unexpected_retire", 16'd1, 16'd0);
            else begin
               e = exp_q.pop_front();
               check("retire_kind", 16'(e.kind), 16'd2);
               pc_pend = 1;
               pc_exp  = e.addr;
            end
         end
      end
   end

   initial begin : main
      int i, base;
      for (int k = 0; k < 256; k++) begin
         ref_mem[k] = 16'($urandom);
         env_mem[k] = ref_mem[k];
      end
      ref_mem[7] = 16'd9;
      env_mem[7] = 16'd9;
      // Directed prefix: A=5; D=A; A=3; M=D-A; A=16; D=0; D;JEQ; D=1; A=16; D;JEQ;
      // A=7; D=1; AMD=M+1; A=-1; 0;JMP (to FFFF); A-instruction at FFFF wraps PC.
      prog_q = '{16'h0005, 16'hEC10, 16'h0003, 16'hE4C8, 16'h0010, 16'hEA90, 16'hE302,
                 16'hEFD0, 16'h0010, 16'hE302, 16'h0007, 16'hEFD0, 16'hFDF8, 16'hEEA0,
                 16'hEA87, 16'h0011};
      repeat (3) @(negedge clk);
      check("rst_imem_req", 16'(imem_req), 16'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_retire", 16'(retire), 16'd0);
      check("rst_dmem_re", 16'(dmem_re), 16'd0);
      check("rst_dmem_we", 16'(dmem_we), 16'd0);
      check("rst_alu_op", 16'(alu_op), 16'd0);
      check("rst_dmem_addr", dmem_addr, 16'd0);
      check("rst_dmem_wdata", dmem_wdata, 16'd0);
      gen_random = 1'b1;
      rst_n = 1'b1;

      for (i = 0; i < 20000 && retire_cnt < N_RETIRE; i++) @(negedge clk);
      check("retire_budget", 16'(retire_cnt >= N_RETIRE), 16'd1);

      gen_random = 1'b0;
      for (i = 0; i < 200 && !(exp_q.size() == 0 && imem_req); i++) @(negedge clk);
      check("drain_budget", 16'(exp_q.size()), 16'd0);

      // Stall a store, then reset in the middle of it.
      hold_wr = 1'b1;
      prog_q.push_back(16'h0005);
      prog_q.push_back(16'hEA88);
      for (i = 0; i < 200 && !dmem_we; i++) @(negedge clk);
      check("memwr_reached", 16'(dmem_we), 16'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_dmem_we", 16'(dmem_we), 16'd0);
      check("midrst_pc", pc, RST_PC);
      check("midrst_imem_req", 16'(imem_req), 16'd0);
      check("midrst_retire", 16'(retire), 16'd0);
      repeat (3) @(negedge clk);
      hold_wr = 1'b0;
      prog_q.push_back(16'h1234);
      base = retire_cnt;
      rst_n = 1'b1;
      for (i = 0; i < 50 && retire_cnt == base; i++) @(negedge clk);
      check("post_reset_retire", 16'(retire_cnt - base), 16'd1);
      repeat (3) @(negedge clk);
      check("pc_after_reset_fetch", pc, RST_PC + 16'd1);
      check("final_queue_empty", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
